// File: rtl/alu_result_pipe_if.sv
// alu_result_pipe_if: bundle of handshake and data signals for alu_result_pipe.
//   master : the side that drives operations in and consumes results
//            (in_valid, opcode, op_data, out_ready out; in_ready,
//             out_valid, alu_out, op_err, result_count, err_count in)
//   slave  : the pipeline itself (mirror directions)
interface alu_result_pipe_if #(
  parameter int DATA_WIDTH = 1024,
  parameter int NUM_OPS    = 8,
  parameter int OP_WIDTH   = 3
);
  logic                          in_valid;
  logic                          in_ready;
  logic [OP_WIDTH-1:0]           opcode;
  logic [NUM_OPS*DATA_WIDTH-1:0] op_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         alu_out;
  logic                          op_err;
  logic [15:0]                   result_count;
  logic [7:0]                    err_count;

  modport master (
    output in_valid, opcode, op_data, out_ready,
    input  in_ready, out_valid, alu_out, op_err, result_count, err_count
  );

  modport slave (
    input  in_valid, opcode, op_data, out_ready,
    output in_ready, out_valid, alu_out, op_err, result_count, err_count
  );
endinterface

// File: rtl/alu_result_pipe.sv
// alu_result_pipe: two-stage valid/ready pipeline that forwards one of
// NUM_OPS result sources selected by an opcode.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : alu_result_pipe_if slave port
//          input side  : in_valid/in_ready, opcode, op_data (flattened sources)
//          output side : out_valid/out_ready, alu_out, op_err
//          status      : result_count (wrapping), err_count (saturating)
// Stage S1 registers the raw opcode and all sources; the mux sits between
// S1 and S2 so the wide selection never sits on the input path.
module alu_result_pipe #(
  parameter int DATA_WIDTH = 1024,
  parameter int NUM_OPS    = 8,
  parameter int OP_WIDTH   = 3
) (
  input logic             clk,
  input logic             rst,
  alu_result_pipe_if.slave bus
);

  logic                          s1_valid_q, s1_valid_d;
  logic [OP_WIDTH-1:0]           s1_op_q, s1_op_d;
  logic [NUM_OPS*DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                          s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]         s2_data_q, s2_data_d;
  logic                          s2_err_q, s2_err_d;
  logic [15:0]                   result_count_q, result_count_d;
  logic [7:0]                    err_count_q, err_count_d;

  logic                  s2_free;
  logic                  s1_move;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  op_legal;
  logic [DATA_WIDTH-1:0] sel_data;

  assign out_xfer = s2_valid_q && bus.out_ready;
  assign s2_free  = !s2_valid_q || bus.out_ready;
  assign s1_move  = s1_valid_q && s2_free;
  // Held low during reset so nothing is accepted into a stage being cleared.
  assign bus.in_ready = !rst && (!s1_valid_q || s1_move);
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign op_legal = 32'(s1_op_q) < NUM_OPS;

  // Out-of-range opcodes fall through to the zero default.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (32'(s1_op_q) == k) begin
        sel_data = s1_data_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_op_d        = s1_op_q;
    s1_data_d      = s1_data_q;
    s2_valid_d     = s2_valid_q;
    s2_data_d      = s2_data_q;
    s2_err_d       = s2_err_q;
    result_count_d = result_count_q;
    err_count_d    = err_count_q;

    if (s1_move) begin
      s1_valid_d = 1'b0;
    end
    // A refill in the same cycle S1 drains overrides the clear above.
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_op_d    = bus.opcode;
      s1_data_d  = bus.op_data;
    end

    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_data_d  = sel_data;
      s2_err_d   = !op_legal;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (out_xfer) begin
      result_count_d = result_count_q + 16'd1;
      if (s2_err_q && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_data_q      <= '0;
      s2_err_q       <= 1'b0;
      result_count_q <= '0;
      err_count_q    <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s2_valid_q     <= s2_valid_d;
      s2_data_q      <= s2_data_d;
      s2_err_q       <= s2_err_d;
      result_count_q <= result_count_d;
      err_count_q    <= err_count_d;
    end
  end

  // S1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    s1_op_q   <= s1_op_d;
    s1_data_q <= s1_data_d;
  end

  assign bus.out_valid    = s2_valid_q;
  assign bus.alu_out      = s2_data_q;
  assign bus.op_err       = s2_err_q;
  assign bus.result_count = result_count_q;
  assign bus.err_count    = err_count_q;

endmodule

// File: tb/tb_alu_result_pipe.sv
module tb_alu_result_pipe;
  localparam int AW  = 1024;
  localparam int AN  = 8;
  localparam int BW  = 16;
  localparam int BN  = 5;
  localparam int OPW = 3;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  alu_result_pipe_if #(.DATA_WIDTH(AW), .NUM_OPS(AN), .OP_WIDTH(OPW)) ifa ();
  alu_result_pipe_if #(.DATA_WIDTH(BW), .NUM_OPS(BN), .OP_WIDTH(OPW)) ifb ();

  alu_result_pipe #(.DATA_WIDTH(AW), .NUM_OPS(AN), .OP_WIDTH(OPW)) dut_a (
    .clk(clk), .rst(rst_a), .bus(ifa));
  alu_result_pipe #(.DATA_WIDTH(BW), .NUM_OPS(BN), .OP_WIDTH(OPW)) dut_b (
    .clk(clk), .rst(rst_b), .bus(ifb));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a result is source[op] for legal opcodes, else 0 with error.
  typedef struct {
    logic [BW-1:0] d;
    logic          e;
  } res_t;

  function automatic res_t ref_b(input logic [OPW-1:0] op, input logic [BN*BW-1:0] data);
    res_t r;
    if (int'(op) < BN) begin
      r.d = BW'(data >> (int'(op) * BW));
      r.e = 1'b0;
    end else begin
      r.d = '0;
      r.e = 1'b1;
    end
    return r;
  endfunction

  // Scoreboard for dut_b: queue of results in flight, plus delivered totals.
  res_t          exp_q[$];
  int unsigned   mdl_res = 0;
  int unsigned   mdl_err = 0;
  bit            prev_stall = 1'b0;
  logic [BW-1:0] prev_d;
  logic          prev_e;
  res_t          head;
  logic [7:0]    ec_exp;
  bit            ir_exp;

  always @(negedge clk) begin
    if (rst_b) begin
      exp_q.delete();
      mdl_res    = 0;
      mdl_err    = 0;
      prev_stall = 1'b0;
    end else begin
      ec_exp = (mdl_err > 255) ? 8'hFF : 8'(mdl_err);
      chk("b_result_count", ifb.result_count == 16'(mdl_res), 64'(ifb.result_count), 64'(16'(mdl_res)));
      chk("b_err_count", ifb.err_count == ec_exp, 64'(ifb.err_count), 64'(ec_exp));
      ir_exp = (exp_q.size() < 2) || ifb.out_ready;
      chk("b_in_ready", ifb.in_ready == ir_exp, 64'(ifb.in_ready), 64'(ir_exp));
      if (prev_stall) begin
        chk("b_hold_valid", ifb.out_valid == 1'b1, 64'(ifb.out_valid), 64'd1);
        chk("b_hold_data", ifb.alu_out == prev_d, 64'(ifb.alu_out), 64'(prev_d));
        chk("b_hold_err", ifb.op_err == prev_e, 64'(ifb.op_err), 64'(prev_e));
      end
      if (ifb.out_valid && ifb.out_ready) begin
        chk("b_out_expected", exp_q.size() != 0, 64'(exp_q.size()), 64'd1);
        mdl_res++;
        if (exp_q.size() != 0) begin
          head = exp_q.pop_front();
          chk("b_out_data", ifb.alu_out == head.d, 64'(ifb.alu_out), 64'(head.d));
          chk("b_out_err", ifb.op_err == head.e, 64'(ifb.op_err), 64'(head.e));
          if (head.e) mdl_err++;
        end
      end
      if (ifb.in_valid && ifb.in_ready) begin
        exp_q.push_back(ref_b(ifb.opcode, ifb.op_data));
      end
      prev_stall = ifb.out_valid && !ifb.out_ready;
      prev_d     = ifb.alu_out;
      prev_e     = ifb.op_err;
    end
  end

  task automatic send_b(input logic [OPW-1:0] op, input logic [BN*BW-1:0] data);
    int t = 0;
    bit acc = 1'b0;
    ifb.in_valid = 1'b1;
    ifb.opcode   = op;
    ifb.op_data  = data;
    do begin
      @(negedge clk);
      acc = ifb.in_ready;
      step();
      t++;
    end while (!acc && t < 1000);
    chk("b_send_timeout", acc, 64'(acc), 64'd1);
    ifb.in_valid = 1'b0;
  endtask

  task automatic drain_b();
    int t = 0;
    ifb.out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    step();
    chk("b_drain_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_b();
    ifb.in_valid = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
  endtask

  typedef struct {
    logic [OPW-1:0] op;
    logic [BW-1:0]  d;
    logic           e;
    int             ec;
  } vec_t;

  vec_t              tbl[8];
  logic [BN*BW-1:0]  data_tbl;
  logic [AN*AW-1:0]  data_a;
  logic [AW-1:0]     exp_a;
  logic [95:0]       rnd;
  logic [BN*BW-1:0]  bp_data[4];
  bit                done;

  initial begin
    #990000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.in_valid = 1'b0; ifa.opcode = '0; ifa.op_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.opcode = '0; ifb.op_data = '0; ifb.out_ready = 1'b0;
    step();
    step();

    // Reset state of both instances
    chk("rst_a_in_ready", ifa.in_ready == 1'b0, 64'(ifa.in_ready), 64'd0);
    chk("rst_a_out_valid", ifa.out_valid == 1'b0, 64'(ifa.out_valid), 64'd0);
    chk("rst_a_alu_out", ifa.alu_out == '0, 64'(ifa.alu_out), 64'd0);
    chk("rst_a_result_count", ifa.result_count == 16'd0, 64'(ifa.result_count), 64'd0);
    chk("rst_b_in_ready", ifb.in_ready == 1'b0, 64'(ifb.in_ready), 64'd0);
    chk("rst_b_op_err", ifb.op_err == 1'b0, 64'(ifb.op_err), 64'd0);
    chk("rst_b_err_count", ifb.err_count == 8'd0, 64'(ifb.err_count), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("rel_a_in_ready", ifa.in_ready == 1'b1, 64'(ifa.in_ready), 64'd1);
    chk("rel_b_in_ready", ifb.in_ready == 1'b1, 64'(ifb.in_ready), 64'd1);
    step();

    // Full-width stream: opcodes 0..7 back to back, source k = k+1 in every word
    for (int k = 0; k < AN; k++)
      for (int w = 0; w < AW/32; w++)
        data_a[k*AW + w*32 +: 32] = 32'(k + 1);
    ifa.out_ready = 1'b1;
    ifa.op_data   = data_a;
    for (int c = 0; c <= 10; c++) begin
      if (c >= 2 && c <= 9) begin
        for (int w = 0; w < AW/32; w++) exp_a[w*32 +: 32] = 32'(c - 1);
        chk("a_stream_valid", ifa.out_valid == 1'b1, 64'(ifa.out_valid), 64'd1);
        chk("a_stream_data", ifa.alu_out == exp_a, ifa.alu_out[63:0], exp_a[63:0]);
        chk("a_stream_err", ifa.op_err == 1'b0, 64'(ifa.op_err), 64'd0);
      end else begin
        chk("a_stream_idle", ifa.out_valid == 1'b0, 64'(ifa.out_valid), 64'd0);
      end
      if (c < 8) begin
        chk("a_stream_in_ready", ifa.in_ready == 1'b1, 64'(ifa.in_ready), 64'd1);
        ifa.in_valid = 1'b1;
        ifa.opcode   = OPW'(c);
      end else begin
        ifa.in_valid = 1'b0;
      end
      step();
    end
    chk("a_stream_count", ifa.result_count == 16'd8, 64'(ifa.result_count), 64'd8);

    // Table-driven single operations on the 5-source instance
    data_tbl = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    tbl[0] = '{3'd0, 16'h1111, 1'b0, 0};
    tbl[1] = '{3'd4, 16'h5555, 1'b0, 0};
    tbl[2] = '{3'd5, 16'h0000, 1'b1, 1};
    tbl[3] = '{3'd6, 16'h0000, 1'b1, 2};
    tbl[4] = '{3'd2, 16'h3333, 1'b0, 2};
    tbl[5] = '{3'd7, 16'h0000, 1'b1, 3};
    tbl[6] = '{3'd1, 16'h2222, 1'b0, 3};
    tbl[7] = '{3'd3, 16'h4444, 1'b0, 3};
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_b(tbl[i].op, data_tbl);
      chk("tbl_latency", ifb.out_valid == 1'b0, 64'(ifb.out_valid), 64'd0);
      step();
      chk("tbl_valid", ifb.out_valid == 1'b1, 64'(ifb.out_valid), 64'd1);
      chk("tbl_alu_out", ifb.alu_out == tbl[i].d, 64'(ifb.alu_out), 64'(tbl[i].d));
      chk("tbl_op_err", ifb.op_err == tbl[i].e, 64'(ifb.op_err), 64'(tbl[i].e));
      step();
      chk("tbl_valid_drop", ifb.out_valid == 1'b0, 64'(ifb.out_valid), 64'd0);
      chk("tbl_err_count", ifb.err_count == 8'(tbl[i].ec), 64'(ifb.err_count), 64'(tbl[i].ec));
    end
    chk("tbl_result_count", ifb.result_count == 16'd8, 64'(ifb.result_count), 64'd8);

    // Backpressure: two accepted, then stall with a third held at the input
    reset_b();
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      bp_data[i] = rnd[BN*BW-1:0];
    end
    ifb.out_ready = 1'b0;
    send_b(3'd0, bp_data[0]);
    send_b(3'd1, bp_data[1]);
    chk("bp_in_ready_low", ifb.in_ready == 1'b0, 64'(ifb.in_ready), 64'd0);
    ifb.in_valid = 1'b1;
    ifb.opcode   = 3'd2;
    ifb.op_data  = bp_data[2];
    head = ref_b(3'd0, bp_data[0]);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_stall_in_ready", ifb.in_ready == 1'b0, 64'(ifb.in_ready), 64'd0);
      chk("bp_stall_valid", ifb.out_valid == 1'b1, 64'(ifb.out_valid), 64'd1);
      chk("bp_stall_data", ifb.alu_out == head.d, 64'(ifb.alu_out), 64'(head.d));
    end
    ifb.out_ready = 1'b1;
    send_b(3'd2, bp_data[2]);
    send_b(3'd7, bp_data[3]);
    drain_b();
    chk("bp_result_count", ifb.result_count == 16'd4, 64'(ifb.result_count), 64'd4);
    chk("bp_err_count", ifb.err_count == 8'd1, 64'(ifb.err_count), 64'd1);

    // Reset with both stages full: everything in flight is discarded
    ifb.out_ready = 1'b0;
    send_b(3'd3, bp_data[0]);
    send_b(3'd6, bp_data[1]);
    chk("mr_full_in_ready", ifb.in_ready == 1'b0, 64'(ifb.in_ready), 64'd0);
    rst_b = 1'b1;
    #1;
    chk("mr_rst_in_ready", ifb.in_ready == 1'b0, 64'(ifb.in_ready), 64'd0);
    step();
    chk("mr_out_valid", ifb.out_valid == 1'b0, 64'(ifb.out_valid), 64'd0);
    chk("mr_result_count", ifb.result_count == 16'd0, 64'(ifb.result_count), 64'd0);
    chk("mr_err_count", ifb.err_count == 8'd0, 64'(ifb.err_count), 64'd0);
    rst_b = 1'b0;
    #1;
    chk("mr_rel_in_ready", ifb.in_ready == 1'b1, 64'(ifb.in_ready), 64'd1);
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_no_stale", ifb.out_valid == 1'b0, 64'(ifb.out_valid), 64'd0);
    end

    // Randomized traffic with random gaps and random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 3) == 0) step();
          rnd = {$urandom, $urandom, $urandom};
          send_b(OPW'($urandom_range(0, 7)), rnd[BN*BW-1:0]);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ifb.out_ready = ($urandom_range(0, 9) < 7);
          step();
        end
      end
    join
    drain_b();

    // Counter boundaries: 65536 transfers, the first 300 illegal
    reset_b();
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      send_b((i < 300) ? 3'd6 : OPW'(i % BN), data_tbl);
    end
    drain_b();
    chk("cnt_wrap", ifb.result_count == 16'd0, 64'(ifb.result_count), 64'd0);
    chk("cnt_saturate", ifb.err_count == 8'hFF, 64'(ifb.err_count), 64'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
